// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//   Multi-cycle adder/subtractor. One DIGIT-wide ripple slice is reused for
//   every digit of the WIDTH-bit operands. The result takes N = WIDTH/DIGIT
//   cycles and runs behind a start/busy/done handshake.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   DIGIT  bits processed per cycle (WIDTH must be a multiple of DIGIT)
//
// Ports
//   clk    in   1      rising-edge clock
//   rstN   in   1      synchronous active-low reset
//   start  in   1      request an operation (sampled in IDLE and DONE only)
//   sub    in   1      0: x + y + cIn    1: x - y (cIn ignored)
//   x, y   in   WIDTH  operands, captured when start is accepted
//   cIn    in   1      carry-in for add mode, captured when start is accepted
//   busy   out  1      high for the N cycles of RUN
//   done   out  1      one-cycle pulse, sum/cOut/ovf were just updated
//   sum    out  WIDTH  result, held until the next completion
//   cOut   out  1      carry out of the MSB (sub: 1 = no borrow)
//   ovf    out  1      signed overflow
// -----------------------------------------------------------------------------
module serial_add_sub #(
   parameter int WIDTH = 5,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cIn,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cOut,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic             accept;     // operands are captured this edge
   logic             last;       // final digit is being processed this edge
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;      // already inverted for subtraction
   logic             carry;
   logic [WIDTH-1:0] work;       // result digits, filled from the top down
   logic [CW-1:0]    count;

   logic [DIGIT-1:0] digit_sum;
   logic             digit_cout;
   logic             digit_cmsb; // carry into the top bit of this digit
   logic             ripple;
   logic [WIDTH-1:0] digit_ext;
   logic [WIDTH-1:0] work_next;

   // ---------------------------------------------------------------- FSM
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (!rstN) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: every output of this block gets a default first; a path that
   // leaves one unassigned would otherwise infer a latch.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (count == LAST_COUNT) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            // Back-to-back: a start seen during the done pulse is taken at once.
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------ digit slice
   // Bit-level ripple through one digit. The carry entering the top bit is
   // kept so the last digit can report signed overflow for any DIGIT.
   always_comb begin
      ripple     = carry;
      digit_sum  = '0;
      digit_cmsb = carry;
      for (int i = 0; i < DIGIT; i++) begin
         digit_sum[i] = a_reg[i] ^ b_reg[i] ^ ripple;
         if (i == DIGIT - 1) digit_cmsb = ripple;
         ripple = (a_reg[i] & b_reg[i]) | (ripple & (a_reg[i] ^ b_reg[i]));
      end
      digit_cout = ripple;
   end

   // New digit enters at the top; after N shifts digit 0 sits at bit 0.
   always_comb begin
      digit_ext              = '0;
      digit_ext[DIGIT-1:0]   = digit_sum;
      work_next              = (work >> DIGIT) | (digit_ext << (WIDTH - DIGIT));
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!rstN) begin
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         work  <= '0;
         count <= '0;
         sum   <= '0;
         cOut  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         // Subtraction is x + ~y + 1: invert B and force the initial carry.
         a_reg <= x;
         b_reg <= y ^ {WIDTH{sub}};
         carry <= sub ? 1'b1 : cIn;
         work  <= '0;
         count <= '0;
      end else if (state == RUN) begin
         a_reg <= a_reg >> DIGIT;
         b_reg <= b_reg >> DIGIT;
         carry <= digit_cout;
         work  <= work_next;
         count <= count + CW'(1);
         if (last) begin
            sum  <= work_next;
            cOut <= digit_cout;
            ovf  <= digit_cmsb ^ digit_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
//   Two instances: WIDTH=5/DIGIT=1 and WIDTH=8/DIGIT=4. Stimulus pushes the
//   hand-computed result and its due cycle into a queue per instance; a
//   monitor per instance pops and compares on every done pulse and checks
//   that outputs hold between completions.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

   localparam int N5 = 5;  // 5 / 1
   localparam int N8 = 2;  // 8 / 4

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      int         due;
   } exp_t;

   exp_t q5[$];
   exp_t q8[$];
   exp_t e5;
   exp_t e8;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 5-bit instance
   logic       start5, sub5, cin5;
   logic [4:0] x5, y5;
   logic       busy5, done5, cout5, ovf5;
   logic [4:0] sum5;

   // 8-bit instance
   logic       start8, sub8, cin8;
   logic [7:0] x8, y8;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] sum8;

   serial_add_sub #(.WIDTH(5), .DIGIT(1)) dut5 (
      .clk(clk), .rstN(rst_n), .start(start5), .sub(sub5), .x(x5), .y(y5),
      .cIn(cin5), .busy(busy5), .done(done5), .sum(sum5), .cOut(cout5), .ovf(ovf5)
   );

   serial_add_sub #(.WIDTH(8), .DIGIT(4)) dut8 (
      .clk(clk), .rstN(rst_n), .start(start8), .sub(sub8), .x(x8), .y(y8),
      .cIn(cin8), .busy(busy8), .done(done8), .sum(sum8), .cOut(cout8), .ovf(ovf8)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------ monitors
   logic [4:0] last_sum5;
   logic       last_c5, last_o5;
   logic [7:0] last_sum8;
   logic       last_c8, last_o8;

   always @(negedge clk) begin
      if (!rst_n) begin
         q5.delete();
         last_sum5 = '0; last_c5 = 1'b0; last_o5 = 1'b0;
      end else if (done5) begin
         if (q5.size() == 0) begin
            checks++; errors++;
            $display("FAIL done5_unexpected: got done=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            e5 = q5.pop_front();
            check("sum5",  32'(sum5),  32'(e5.sum));
            check("cout5", 32'(cout5), 32'(e5.cout));
            check("ovf5",  32'(ovf5),  32'(e5.ovf));
            check("lat5",  cyc,        e5.due);
         end
         last_sum5 = sum5; last_c5 = cout5; last_o5 = ovf5;
      end else begin
         check("hold5_sum",  32'(sum5),  32'(last_sum5));
         check("hold5_cout", 32'(cout5), 32'(last_c5));
         check("hold5_ovf",  32'(ovf5),  32'(last_o5));
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         q8.delete();
         last_sum8 = '0; last_c8 = 1'b0; last_o8 = 1'b0;
      end else if (done8) begin
         if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL done8_unexpected: got done=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            e8 = q8.pop_front();
            check("sum8",  32'(sum8),  32'(e8.sum));
            check("cout8", 32'(cout8), 32'(e8.cout));
            check("ovf8",  32'(ovf8),  32'(e8.ovf));
            check("lat8",  cyc,        e8.due);
         end
         last_sum8 = sum8; last_c8 = cout8; last_o8 = ovf8;
      end else begin
         check("hold8_sum",  32'(sum8),  32'(last_sum8));
         check("hold8_cout", 32'(cout8), 32'(last_c8));
         check("hold8_ovf",  32'(ovf8),  32'(last_o8));
      end
   end

   // ------------------------------------------------------------ drivers
   // Inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns one edge after acceptance, i.e. inside the first RUN cycle.
   task automatic issue5(input logic [4:0] a, input logic [4:0] b, input logic ci,
                         input logic s, input logic [4:0] es, input logic ec,
                         input logic eo);
      x5 = a; y5 = b; cin5 = ci; sub5 = s; start5 = 1'b1;
      q5.push_back('{{3'b000, es}, ec, eo, cyc + 1 + N5});
      step();
      start5 = 1'b0;
      // Scramble inputs: nothing may leak in while RUN is active.
      x5 = ~a; y5 = ~b; cin5 = ~ci; sub5 = ~s;
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic s, input logic [7:0] es, input logic ec,
                         input logic eo);
      x8 = a; y8 = b; cin8 = ci; sub8 = s; start8 = 1'b1;
      q8.push_back('{es, ec, eo, cyc + 1 + N8});
      step();
      start8 = 1'b0;
      x8 = ~a; y8 = ~b; cin8 = ~ci; sub8 = ~s;
   endtask

   task automatic wait_idle5();
      int k = 0;
      while (k < 40 && !(q5.size() == 0 && !busy5 && !done5)) begin
         step();
         k++;
      end
      check("pending5", 32'(q5.size()), 32'd0);
   endtask

   task automatic wait_idle8();
      int k = 0;
      while (k < 40 && !(q8.size() == 0 && !busy8 && !done8)) begin
         step();
         k++;
      end
      check("pending8", 32'(q8.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n  = 1'b0;
      start5 = 1'b0; sub5 = 1'b0; cin5 = 1'b0; x5 = '0; y5 = '0;
      start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; x8 = '0; y8 = '0;
      repeat (3) step();

      // Reset state
      check("rst_busy5", 32'(busy5), 32'd0);
      check("rst_done5", 32'(done5), 32'd0);
      check("rst_sum5",  32'(sum5),  32'd0);
      check("rst_cout5", 32'(cout5), 32'd0);
      check("rst_ovf5",  32'(ovf5),  32'd0);
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_sum8",  32'(sum8),  32'd0);
      rst_n = 1'b1;
      step();

      // 12+9: signed overflow; a start during the 2nd RUN cycle is ignored
      issue5(5'd12, 5'd9, 1'b0, 1'b0, 5'd21, 1'b0, 1'b1);
      check("busy5_run", 32'(busy5), 32'd1);
      step();
      start5 = 1'b1; x5 = 5'd1; y5 = 5'd1;
      step();
      start5 = 1'b0;
      wait_idle5();

      issue5(5'd31, 5'd1,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0); wait_idle5();
      issue5(5'd3,  5'd4,  1'b1, 1'b0, 5'd8,  1'b0, 1'b0); wait_idle5();
      issue5(5'd16, 5'd16, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1); wait_idle5();
      issue5(5'd9,  5'd12, 1'b1, 1'b1, 5'd29, 1'b0, 1'b0); wait_idle5();
      issue5(5'd12, 5'd9,  1'b0, 1'b1, 5'd3,  1'b1, 1'b0); wait_idle5();

      // Reset on the 3rd RUN cycle aborts: outputs clear, no done pulse
      issue5(5'd5, 5'd6, 1'b0, 1'b0, 5'd11, 1'b0, 1'b0);
      step();
      step();
      rst_n = 1'b0;
      step();
      check("abort_busy5", 32'(busy5), 32'd0);
      check("abort_done5", 32'(done5), 32'd0);
      check("abort_sum5",  32'(sum5),  32'd0);
      check("abort_cout5", 32'(cout5), 32'd0);
      check("abort_ovf5",  32'(ovf5),  32'd0);
      rst_n = 1'b1;
      repeat (8) step();
      check("abort_q5", 32'(q5.size()), 32'd0);

      issue5(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0); wait_idle5();

      // 8-bit, two digits: 200+100 wraps; start during DONE is taken at once
      issue8(8'd200, 8'd100, 1'b0, 1'b0, 8'd44, 1'b1, 1'b0);
      k = 0;
      while (!done8 && k < 20) begin
         step();
         k++;
      end
      check("done8_seen", 32'(done8), 32'd1);
      issue8(8'd100, 8'd200, 1'b0, 1'b1, 8'd156, 1'b0, 1'b1);
      check("busy8_b2b", 32'(busy8), 32'd1);
      wait_idle8();

      step();
      check("final_q5", 32'(q5.size()), 32'd0);
      check("final_q8", 32'(q8.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
